tns_enc_19_seq: RTL



---
 rtl/tns_enc_19_seq_pkg.sv | 67 ++++++
 rtl/tns_enc_19_seq_rom.sv | 21 ++
 rtl/tns_enc_19_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/tns_enc_19_seq_pkg.sv
// ============================================================================
// Module : tns_enc_19_seq_pkg
// Brief  : TNS weight table, word widths and encoder state type.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tns_enc_19_seq_pkg;

    localparam int c_blen07_c   = 15;
    localparam int c_tns_code_w = 19;

    localparam logic [c_blen07_c-1:0] c_tns01_c = 15'd1;
    localparam logic [c_blen07_c-1:0] c_tns01_b = 15'd2;
    localparam logic [c_blen07_c-1:0] c_tns01_a = 15'd3;
    localparam logic [c_blen07_c-1:0] c_tns02_c = 15'd5;
    localparam logic [c_blen07_c-1:0] c_tns02_b = 15'd8;
    localparam logic [c_blen07_c-1:0] c_tns02_a = 15'd13;
    localparam logic [c_blen07_c-1:0] c_tns03_c = 15'd21;
    localparam logic [c_blen07_c-1:0] c_tns03_b = 15'd34;
    localparam logic [c_blen07_c-1:0] c_tns03_a = 15'd55;
    localparam logic [c_blen07_c-1:0] c_tns04_c = 15'd89;
    localparam logic [c_blen07_c-1:0] c_tns04_b = 15'd144;
    localparam logic [c_blen07_c-1:0] c_tns04_a = 15'd233;
    localparam logic [c_blen07_c-1:0] c_tns05_c = 15'd377;
    localparam logic [c_blen07_c-1:0] c_tns05_b = 15'd610;
    localparam logic [c_blen07_c-1:0] c_tns05_a = 15'd987;
    localparam logic [c_blen07_c-1:0] c_tns06_c = 15'd1597;
    localparam logic [c_blen07_c-1:0] c_tns06_b = 15'd2584;
    localparam logic [c_blen07_c-1:0] c_tns06_a = 15'd4181;
    localparam logic [c_blen07_c-1:0] c_tns07_c = 15'd6765;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } tns_state_t;

    // Bit index to weight; matches the decoder's mapping (bit18 = TNS07_C).
    function automatic logic [c_blen07_c-1:0] tns_weight(input logic [4:0] idx);
        case (idx)
            5'd0:    tns_weight = c_tns01_c;
            5'd1:    tns_weight = c_tns01_b;
            5'd2:    tns_weight = c_tns01_a;
            5'd3:    tns_weight = c_tns02_c;
            5'd4:    tns_weight = c_tns02_b;
            5'd5:    tns_weight = c_tns02_a;
            5'd6:    tns_weight = c_tns03_c;
            5'd7:    tns_weight = c_tns03_b;
            5'd8:    tns_weight = c_tns03_a;
            5'd9:    tns_weight = c_tns04_c;
            5'd10:   tns_weight = c_tns04_b;
            5'd11:   tns_weight = c_tns04_a;
            5'd12:   tns_weight = c_tns05_c;
            5'd13:   tns_weight = c_tns05_b;
            5'd14:   tns_weight = c_tns05_a;
            5'd15:   tns_weight = c_tns06_c;
            5'd16:   tns_weight = c_tns06_b;
            5'd17:   tns_weight = c_tns06_a;
            5'd18:   tns_weight = c_tns07_c;
            default: tns_weight = '0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/tns_enc_19_seq_rom.sv
// ============================================================================
// Module : tns_weight_rom
// Brief  : Combinational bit-index to TNS weight lookup (19 entries).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tns_weight_rom
    import tns_enc_19_seq_pkg::*;
#(
    parameter int DATA_W = c_blen07_c
) (
    input  logic [4:0]        idx,
    output logic [DATA_W-1:0] weight
);

    assign weight = DATA_W'(tns_weight(idx));

endmodule

`default_nettype wire

// File: rtl/tns_enc_19_seq.sv
// ============================================================================
// Module : tns_enc_19_seq
// Brief  : Iterative greedy TNS encoder, one code bit per clock, MSB first.
//          Optional residual range flag (out_err) via TNS_ENC_RANGE_CHECK_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tns_enc_19_seq
    import tns_enc_19_seq_pkg::*;
#(
    parameter int DATA_W = c_blen07_c,
    parameter int CODE_W = c_tns_code_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code
`ifdef TNS_ENC_RANGE_CHECK_EN
    ,
    output logic              out_err
`endif
);

    localparam logic [4:0] c_idx_msb = 5'(c_tns_code_w - 1);

    generate
        if (CODE_W != c_tns_code_w) begin : g_code_w_check
            $error("tns_enc_19_seq: CODE_W must be 19");
        end
    endgenerate

    tns_state_t        r_state;
    tns_state_t        w_state_nxt;
    logic [DATA_W-1:0] r_rem;
    logic [4:0]        r_idx;
    logic [CODE_W-1:0] r_code;
    logic [DATA_W-1:0] w_weight;
    logic [DATA_W-1:0] w_rem_step;
    logic              w_bit;
    logic              w_accept;
    logic              w_last;

    tns_weight_rom #(
        .DATA_W (DATA_W)
    ) u_rom (
        .idx    (r_idx),
        .weight (w_weight)
    );

    // Greedy step: subtraction is guarded by the compare, so it never wraps.
    assign w_bit      = (r_rem >= w_weight);
    assign w_rem_step = w_bit ? (r_rem - w_weight) : r_rem;
    assign w_last     = (r_idx == 5'd0);
    assign w_accept   = in_valid && in_ready;
    assign out_code   = r_code;

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = !rst;
                if (w_accept) w_state_nxt = S_CALC;
            end
            S_CALC: begin
                if (w_last) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_idx   <= '0;
            r_code  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rem  <= in_data;
                        r_idx  <= c_idx_msb;
                        r_code <= '0;
                    end
                end
                S_CALC: begin
                    r_code[r_idx] <= w_bit;
                    r_rem         <= w_rem_step;
                    if (!w_last) r_idx <= r_idx - 5'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef TNS_ENC_RANGE_CHECK_EN
    logic r_err;

    // A non-zero residual after the last step means the word exceeds Wsum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == S_CALC && w_last) begin
            r_err <= (w_rem_step != '0);
        end else if (r_state == S_DONE && out_ready) begin
            r_err <= 1'b0;
        end
    end

    assign out_err = r_err;
`endif

endmodule

`default_nettype wire
